// File: rtl/adder_tree_lane_packer_pkg.sv
// Shared adder-tree constants: default operand/lane geometry and the packer FSM encoding.
package tree_pkg;

    localparam int TREE_DATA_BITWIDTH   = 8;
    localparam int TREE_BREADTH_OF_TREE = 32;
    localparam int TREE_CNT_W           = $clog2(TREE_BREADTH_OF_TREE);
    localparam int TREE_VEC_W           = TREE_DATA_BITWIDTH * TREE_BREADTH_OF_TREE;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/adder_tree_lane_packer_if.sv
// Serial operand port in, packed lane-vector port out; slave side belongs to the packer.
interface adder_tree_lane_packer_if
    import tree_pkg::*;
#(
    parameter int DATA_BITWIDTH   = TREE_DATA_BITWIDTH,
    parameter int BREADTH_OF_TREE = TREE_BREADTH_OF_TREE
);
    localparam int CNT_W = $clog2(BREADTH_OF_TREE);

    logic                                     s_valid;
    logic                                     s_ready;
    logic [DATA_BITWIDTH-1:0]                 s_data;
    logic                                     s_last;
    logic                                     m_valid;
    logic                                     m_ready;
    logic [DATA_BITWIDTH*BREADTH_OF_TREE-1:0] m_data;
    logic [CNT_W:0]                           m_count;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_count
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_count
    );
endinterface

// File: rtl/adder_tree_lane_packer.sv
// Packs serial operands into a zero-padded lane vector; completing word shows on m_valid one edge later.
// Assembly + output registers give 1 word/cycle under backpressure; s_ready depends on FSM state only.
module adder_tree_lane_packer
    import tree_pkg::*;
#(
    parameter int DATA_BITWIDTH   = TREE_DATA_BITWIDTH,
    parameter int BREADTH_OF_TREE = TREE_BREADTH_OF_TREE
) (
    input  logic                     clk,
    input  logic                     rstN,
    adder_tree_lane_packer_if.slave  pk
);
    localparam int CNT_W = $clog2(BREADTH_OF_TREE);
    localparam int VEC_W = DATA_BITWIDTH * BREADTH_OF_TREE;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BREADTH_OF_TREE - 1);

    pack_state_e        state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [VEC_W-1:0]   asm_q, asm_d;
    logic [VEC_W-1:0]   out_dat_q, out_dat_d;
    logic [CNT_W:0]     out_cnt_q, out_cnt_d;
    logic               out_vld_q, out_vld_d;

    logic               s_acc;
    logic               out_free;
    logic [VEC_W-1:0]   asm_merged;
    logic [CNT_W:0]     close_cnt;

    assign pk.s_ready = (state_q == FILL);
    assign pk.m_valid = out_vld_q;
    assign pk.m_data  = out_dat_q;
    assign pk.m_count = out_cnt_q;

    assign s_acc     = pk.s_valid && (state_q == FILL);
    // The output register can take a new vector if it is empty or being drained this edge.
    assign out_free  = !out_vld_q || pk.m_ready;
    assign close_cnt = {1'b0, idx_q} + (CNT_W + 1)'(1);

    always_comb begin
        asm_merged = asm_q;
        if (s_acc) begin
            asm_merged[idx_q*DATA_BITWIDTH +: DATA_BITWIDTH] = pk.s_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        out_dat_d = out_dat_q;
        out_cnt_d = out_cnt_q;
        out_vld_d = out_vld_q;

        if (out_vld_q && pk.m_ready) begin
            out_vld_d = 1'b0;
        end

        unique case (state_q)
            FILL: begin
                if (s_acc) begin
                    asm_d = asm_merged;
                    if ((idx_q == LAST_IDX) || pk.s_last) begin
                        if (out_free) begin
                            out_dat_d = asm_merged;
                            out_cnt_d = close_cnt;
                            out_vld_d = 1'b1;
                            asm_d     = '0;
                            idx_d     = '0;
                        end else begin
                            // idx stays at the closing lane so HOLD can still derive the count.
                            state_d = HOLD;
                        end
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    out_dat_d = asm_q;
                    out_cnt_d = close_cnt;
                    out_vld_d = 1'b1;
                    asm_d     = '0;
                    idx_d     = '0;
                    state_d   = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= FILL;
            idx_q     <= '0;
            asm_q     <= '0;
            out_dat_q <= '0;
            out_cnt_q <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            asm_q     <= asm_d;
            out_dat_q <= out_dat_d;
            out_cnt_q <= out_cnt_d;
            out_vld_q <= out_vld_d;
        end
    end

endmodule

// File: tb/tb_adder_tree_lane_packer.sv
// Bench for adder_tree_lane_packer: scoreboard of expected vectors plus table-driven early-close cases.
module tb_adder_tree_lane_packer;
    import tree_pkg::*;

    localparam int DW = 8;
    localparam int BT = 32;
    localparam int VW = DW * BT;
    localparam int CW = $clog2(BT) + 1;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    adder_tree_lane_packer_if #(.DATA_BITWIDTH(DW), .BREADTH_OF_TREE(BT)) pk ();

    adder_tree_lane_packer #(.DATA_BITWIDTH(DW), .BREADTH_OF_TREE(BT)) dut (
        .clk  (clk),
        .rstN (rstN),
        .pk   (pk)
    );

    typedef struct {
        logic [VW-1:0] dat;
        logic [CW-1:0] cnt;
    } vec_t;

    typedef struct {
        int            len;
        logic [7:0]    base;
        bit            use_last;
        logic [CW-1:0] exp_cnt;
        logic [7:0]    exp_lane0;
        logic [7:0]    exp_lane31;
    } vec_case_t;

    vec_t          sb_q[$];
    vec_case_t     tbl[5];
    int            checks = 0;
    int            errors = 0;
    int            hs_cnt = 0;
    logic [VW-1:0] m_asm = '0;
    int            m_idx = 0;
    bit            watch_rdy = 0;
    bit            rdy_drop = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        vec_t e;
        if (watch_rdy && !pk.s_ready) rdy_drop = 1;
        if (rstN === 1'b1 && pk.m_valid && pk.m_ready) begin
            hs_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got vector %0h want none", pk.m_data);
            end else begin
                e = sb_q.pop_front();
                chk("sb_data", pk.m_data, e.dat);
                chk("sb_count", VW'(pk.m_count), VW'(e.cnt));
            end
        end
    end

    // Drives one word; reference model is updated only once the packer takes it.
    task automatic send(input logic [7:0] d, input bit last);
        int t = 0;
        vec_t v;
        pk.s_valid = 1'b1;
        pk.s_data  = d;
        pk.s_last  = last;
        @(negedge clk);
        while (!pk.s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!pk.s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_ready 0 want 1");
        end else begin
            m_asm[m_idx*DW +: DW] = d;
            if (m_idx == BT - 1 || last) begin
                v.dat = m_asm;
                v.cnt = CW'(m_idx + 1);
                sb_q.push_back(v);
                m_asm = '0;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        @(posedge clk);
        #1;
        pk.s_valid = 1'b0;
        pk.s_last  = 1'b0;
    endtask

    task automatic wait_vld(input string name);
        int t = 0;
        while (!pk.m_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk(name, VW'(pk.m_valid), VW'(1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstN = 1'b0;
        #2;
        chk("rst_m_valid", VW'(pk.m_valid), '0);
        chk("rst_m_data", pk.m_data, '0);
        chk("rst_m_count", VW'(pk.m_count), '0);
        chk("rst_s_ready", VW'(pk.s_ready), VW'(1));
        sb_q.delete();
        m_asm = '0;
        m_idx = 0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        chk("post_rst_s_ready", VW'(pk.s_ready), VW'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs0;
        tbl[0] = '{5,  8'hA1, 1'b1, CW'(5),  8'hA1, 8'h00};
        tbl[1] = '{1,  8'h11, 1'b1, CW'(1),  8'h11, 8'h00};
        tbl[2] = '{31, 8'h01, 1'b1, CW'(31), 8'h01, 8'h00};
        tbl[3] = '{32, 8'hC0, 1'b0, CW'(32), 8'hC0, 8'hDF};
        tbl[4] = '{32, 8'hE0, 1'b1, CW'(32), 8'hE0, 8'hFF};

        rstN       = 1'b0;
        pk.s_valid = 1'b0;
        pk.s_data  = '0;
        pk.s_last  = 1'b0;
        pk.m_ready = 1'b1;
        do_reset();

        // Full vector, consumer always ready: lane i = i+1, m_valid pulses for one cycle.
        for (int i = 0; i < BT; i++) send(8'(i + 1), 1'b0);
        chk("full_m_valid_next", VW'(pk.m_valid), VW'(1));
        chk("full_m_count", VW'(pk.m_count), VW'(32));
        @(posedge clk);
        #1;
        chk("full_m_valid_one_cycle", VW'(pk.m_valid), '0);

        for (int k = 0; k < 5; k++) begin
            pk.m_ready = 1'b0;
            for (int i = 0; i < tbl[k].len; i++)
                send(8'(tbl[k].base + 8'(i)), tbl[k].use_last && (i == tbl[k].len - 1));
            wait_vld("tbl_m_valid");
            chk("tbl_m_count", VW'(pk.m_count), VW'(tbl[k].exp_cnt));
            chk("tbl_lane0", VW'(pk.m_data[DW-1:0]), VW'(tbl[k].exp_lane0));
            chk("tbl_lane31", VW'(pk.m_data[VW-1 -: DW]), VW'(tbl[k].exp_lane31));
            pk.m_ready = 1'b1;
            @(posedge clk);
            #1;
        end

        // Backpressure: two vectors queued, then drained on consecutive edges.
        pk.m_ready = 1'b0;
        for (int i = 0; i < 2 * BT; i++) send(8'(i) ^ 8'h5A, 1'b0);
        chk("bp_s_ready_low", VW'(pk.s_ready), '0);
        hs0 = hs_cnt;
        pk.m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_vec2_no_gap", VW'(pk.m_valid), VW'(1));
        chk("bp_s_ready_back", VW'(pk.s_ready), VW'(1));
        @(posedge clk);
        #1;
        chk("bp_drained", VW'(pk.m_valid), '0);
        chk("bp_two_vectors", VW'(hs_cnt - hs0), VW'(2));

        // Completion on the same edge as the output register drains.
        pk.m_ready = 1'b0;
        for (int i = 0; i < BT; i++) send(8'(8'h80 + i), 1'b0);
        rdy_drop  = 0;
        watch_rdy = 1;
        for (int i = 0; i < BT - 1; i++) send(8'(8'h20 + i), 1'b0);
        pk.m_ready = 1'b1;
        send(8'h3F, 1'b0);
        chk("simul_no_bubble", VW'(pk.m_valid), VW'(1));
        chk("simul_count", VW'(pk.m_count), VW'(32));
        watch_rdy = 0;
        chk("simul_s_ready_steady", VW'(rdy_drop), '0);
        @(posedge clk);
        #1;

        // Reset with a held vector and a 10-word partial: both discarded.
        pk.m_ready = 1'b0;
        for (int i = 0; i < BT; i++) send(8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 10; i++) send(8'(8'h90 + i), 1'b0);
        do_reset();
        pk.m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_vector", VW'(pk.m_valid), '0);
        pk.m_ready = 1'b0;
        hs0 = hs_cnt;
        for (int i = 0; i < BT; i++) send(8'(8'h40 + i), 1'b0);
        wait_vld("rst_next_m_valid");
        chk("rst_next_lane0", VW'(pk.m_data[DW-1:0]), VW'(8'h40));
        chk("rst_next_count", VW'(pk.m_count), VW'(32));
        chk("rst_no_extra_hs", VW'(hs_cnt - hs0), '0);
        pk.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        chk("sb_empty", VW'(sb_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
